// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops a show-ahead FIFO into a 2-entry skid buffer and
// presents the words as a framed valid/ready stream with a packet counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  // Slot p0 is the head presented downstream, slot p1 the skid entry behind it.
  logic [DATA_WIDTH-1:0] data_p0, data_p1;
  logic                  last_p0, last_p1;
  logic [1:0]            occ;
  logic [7:0]            word_idx;

  logic       pop;
  logic       xfer;
  logic       pop_last;
  logic [1:0] occ_after_xfer;

  assign pop            = rst_n & enable & ~fifo_empty & (occ != 2'd2);
  assign xfer           = m_valid & m_ready;
  assign pop_last       = (word_idx == LAST_IDX);
  assign occ_after_xfer = occ - {1'b0, xfer};

  assign fifo_rd_en = pop;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = data_p0;
  assign m_last     = last_p0;
  assign busy       = m_valid;

  // Stage boundary: skid buffer, framing counter and packet counter
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0   <= '0;
      data_p1   <= '0;
      last_p0   <= 1'b0;
      last_p1   <= 1'b0;
      occ       <= 2'd0;
      word_idx  <= 8'd0;
      pkt_count <= 16'd0;
    end else begin
      occ <= occ + {1'b0, pop} - {1'b0, xfer};
      if (xfer) begin
        data_p0 <= data_p1;
        last_p0 <= last_p1;
        data_p1 <= '0;
        last_p1 <= 1'b0;
      end
      // A pop lands in whichever slot is the tail once this edge's transfer is applied.
      if (pop) begin
        if (occ_after_xfer == 2'd0) begin
          data_p0 <= fifo_data;
          last_p0 <= pop_last;
        end else begin
          data_p1 <= fifo_data;
          last_p1 <= pop_last;
        end
        word_idx <= pop_last ? 8'd0 : word_idx + 8'd1;
      end
      if (xfer && last_p0)
        pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based stream model plus directed scenarios
// (reset, streaming, back-pressure, enable gating, mid-packet reset, PKT_LEN=1).
module tb_fifo_rd_stream;

  localparam int PL = 4;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        m_ready;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] pkt_count;
  logic        busy;

  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  int          pop_cnt = 0;

  logic        rst1_n;
  logic        fifo_rd_en1, m_valid1, m_last1, busy1;
  logic [7:0]  m_data1;
  logic [15:0] pkt_count1;
  logic [7:0]  cnt1 = 8'd0;
  int          xfers1 = 0;
  int          lasts1 = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int lbd[0:255];

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;
  ent_t        mq[$];
  int          npop = 0;
  logic [15:0] mpkt = 16'd0;

  always #5 rd_clk = ~rd_clk;

  // Source FIFO: word value equals its index, show-ahead head.
  assign fifo_empty = (rd_ptr >= wr_ptr);
  assign fifo_data  = rd_ptr;
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
    if (fifo_rd_en1) cnt1 <= cnt1 + 8'd1;
  end

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(PL)) u_dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pkt_count(pkt_count), .busy(busy)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(1)) u_dut1 (
    .rd_clk(rd_clk), .rst_n(rst1_n), .enable(1'b1), .fifo_empty(cnt1 >= 8'd5),
    .fifo_data(cnt1), .fifo_rd_en(fifo_rd_en1), .m_valid(m_valid1),
    .m_ready(1'b1), .m_data(m_data1), .m_last(m_last1),
    .pkt_count(pkt_count1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  // Model: words leave in pop order; every PL-th word since reset ends a packet;
  // at most two words are held between pop and transfer.
  initial begin
    forever begin
      @(posedge rd_clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        npop = 0;
        mpkt = 16'd0;
      end else begin
        automatic bit   do_pop = enable && !fifo_empty && (mq.size() < 2);
        automatic bit   do_xf  = (mq.size() != 0) && m_ready;
        automatic ent_t e;
        if (do_xf) begin
          e = mq.pop_front();
          if (e.l) mpkt = mpkt + 16'd1;
        end
        if (do_pop) begin
          e.d = fifo_data;
          e.l = ((npop % PL) == PL - 1);
          mq.push_back(e);
          npop++;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus transfer logging.
  initial begin
    forever begin
      @(negedge rd_clk);
      check("rd_en", fifo_rd_en, rst_n && enable && !fifo_empty && (mq.size() < 2));
      check("m_valid", m_valid, mq.size() != 0);
      check("busy", busy, mq.size() != 0);
      check("pkt_count", pkt_count, mpkt);
      if (mq.size() != 0) begin
        check("m_data", m_data, mq[0].d);
        check("m_last", m_last, mq[0].l);
      end
      if (m_valid && m_ready) lbd[m_data] = m_last;
      if (m_valid1) begin
        check("p1_data", m_data1, xfers1);
        check("p1_last", m_last1, 1);
        xfers1++;
        if (m_last1) lasts1++;
      end
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) lbd[i] = -1;
    rst_n   = 1'b0;
    rst1_n  = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    wr_ptr  = 8'd12;

    // Reset / idle with data available
    tick(); tick(); tick();
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    #1;
    check("first_pop", fifo_rd_en, 1);
    check("first_valid_lat", m_valid, 0);
    tick();
    #1;
    check("first_valid", m_valid, 1);
    check("first_data", m_data, 0);

    // Streaming 0x00..0x0B
    repeat (16) tick();
    check("stream_pops", pop_cnt, 12);
    check("stream_pkts", pkt_count, 3);
    check("last_03", lbd[3], 1);
    check("last_07", lbd[7], 1);
    check("last_0b", lbd[11], 1);
    check("nolast_02", lbd[2], 0);

    // Back-pressure stall of 5 cycles
    wr_ptr = 8'd24;
    repeat (3) tick();
    m_ready = 1'b0;
    repeat (5) tick();
    #1;
    check("stall_rd_en", fifo_rd_en, 0);
    check("stall_valid", m_valid, 1);
    m_ready = 1'b1;
    repeat (20) tick();
    check("bp_pops", pop_cnt, 24);
    check("bp_pkts", pkt_count, 6);

    // Enable gating after word 29 (position 5 of this run)
    wr_ptr = 8'd40;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (rd_ptr == 8'd30) found = 1'b1;
    end
    check("en_wait", found, 1);
    enable = 1'b0;
    repeat (10) tick();
    check("en_drained", m_valid, 0);
    check("en_nopop", rd_ptr, 30);
    enable = 1'b1;
    repeat (25) tick();
    check("en_pkts", pkt_count, 10);
    check("en_last_31", lbd[31], 1);
    check("en_nolast_29", lbd[29], 0);

    // Mid-packet reset with two words buffered
    m_ready = 1'b0;
    wr_ptr  = 8'd60;
    repeat (4) tick();
    check("mr_popped", rd_ptr, 42);
    check("mr_full_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", m_valid, 0);
    check("mr_pkt", pkt_count, 0);
    check("mr_rd_en", fifo_rd_en, 0);
    tick(); tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    repeat (25) tick();
    check("mr_pkts", pkt_count, 4);
    check("mr_last_45", lbd[45], 1);
    check("mr_nolast_44", lbd[44], 0);
    check("mr_drop_40", lbd[40], 32'hFFFF_FFFF);

    // PKT_LEN=1 instance ran alongside
    check("p1_xfers", xfers1, 5);
    check("p1_lasts", lasts1, 5);
    check("p1_pkts", pkt_count1, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the dual-clock FIFO. It runs in the FIFO's read clock domain and pops words from the FIFO's show-ahead read port (head data valid whenever not empty). It re-presents those words as a registered valid/ready stream with a 2-entry skid buffer. The stream is framed into fixed-length packets with an end-of-packet marker and a completed-packet counter.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO's data width.
- PKT_LEN, 4, words per packet; legal range 1..256.
- rd_clk  in  1  read-domain clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when high, new pops are allowed; when low, no pops, but buffered words still drain.
- fifo_empty  in  1  FIFO empty flag, read domain.
- fifo_data  in  DATA_WIDTH  FIFO head word; valid when fifo_empty=0; advances the cycle after a pop.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks the final word of a packet.
- pkt_count  out  16  packets completed downstream, wraps modulo 2^16.
- busy  out  1  skid buffer non-empty.

## Operation
- Storage: 2-entry FIFO of {data, last} and a 2-bit occupancy `occ` (0..2).
- Pop rule:
  - fifo_rd_en = rst_n & enable & ~fifo_empty & (occ != 2).
  - fifo_rd_en is purely combinational from registered state plus enable/fifo_empty. It never depends on m_ready.
- On a pop edge, fifo_data is written into the buffer tail with last = (word_idx == PKT_LEN-1).
- word_idx counter (8-bit):
  - increments per pop;
  - wraps to 0 after PKT_LEN-1;
  - holds while no pop occurs.
- Transfer occurs on an edge with m_valid & m_ready.
  - The head entry is removed; the second entry, if present, becomes head.
- Occupancy update per edge: occ += pop - transfer. Simultaneous pop and transfer leaves occ unchanged.
  - With occ=1, this sustains 1 word per cycle.
  - A pop with occ=0 and no transfer makes occ=1.
- Outputs, all driven from registers or the head entry:
  - m_valid = (occ != 0);
  - m_data / m_last = head entry;
  - busy = m_valid.
- Stability: while m_valid & ~m_ready, m_data and m_last hold unchanged.
- pkt_count increments on each transfer with m_last=1.
- enable low mid-packet:
  - word_idx is preserved;
  - packet framing resumes exactly when enable returns;
  - buffered words continue to drain.
- PKT_LEN=1: every word has m_last=1.
- Reset (asynchronous, including mid-packet):
  - buffer cleared, occ=0, word_idx=0, pkt_count=0;
  - in-flight buffered words are discarded;
  - fifo_rd_en=0 while rst_n=0.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_count=0, busy=0.
- Latency: fifo_rd_en high in cycle C, so the word is on m_data with m_valid=1 in cycle C+1.
- Back-pressure:
  - After m_ready falls, at most 2 words are buffered.
  - fifo_rd_en drops in the same cycle occ reaches 2.
  - No word is dropped or duplicated.
- Recovery: m_ready rising with occ=2 gives transfers on consecutive edges. A new pop is allowed from the cycle occ becomes 1.
- fifo_empty is treated as a same-cycle qualifier. The block never pops when fifo_empty=1.
- pkt_count updates on the edge of the m_last transfer and is visible the next cycle.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 with fifo_empty=0 and enable=1.
  - Required: fifo_rd_en=0 and all outputs at reset values.
  - After release: first pop in the first cycle; m_valid=1 the cycle after.
- Streaming: FIFO preloaded with 0x00..0x0B, m_ready=1, PKT_LEN=4.
  - fifo_rd_en high for 12 consecutive cycles;
  - m_data 0x00..0x0B, one per cycle;
  - m_last on 0x03, 0x07, 0x0B;
  - pkt_count=3 at the end.
- Back-pressure:
  - Stimulus: drop m_ready for 5 cycles while streaming.
  - Required: occ saturates at 2; fifo_rd_en=0 during the stall; m_data held.
  - After m_ready returns: the sequence continues with no gaps or duplicates.
- Enable gating:
  - Stimulus: deassert enable after word 0x05, then reassert 10 cycles later.
  - Required: buffered words drain; no pops while enable=0; 0x07 still carries m_last=1.
- Mid-packet reset:
  - Stimulus: assert rst_n=0 with occ=2 and word_idx=2.
  - Required: m_valid=0 immediately, pkt_count=0.
  - After release: the next popped word starts a new packet, with m_last on its 4th word.
- PKT_LEN=1 build: 5 words -> m_last=1 on all five, pkt_count=5.
